// File: rtl/mdio_pkg.sv
// mdio_pkg: shared widths, FSM state encoding and constants for the
// MDIO requester arbiter (mdio_arb) and its round-robin picker.
package mdio_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  // Read value reported when the driver never answers.
  localparam logic [DATA_W-1:0] TIMEOUT_RD_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mdio_rr_pick.sv
// mdio_rr_pick: combinational round-robin selector.
//   pending    : one bit per requester with a queued operation
//   last_grant : index of the requester served most recently
//   winner     : first pending index found searching upward from
//                last_grant+1, wrapping modulo NUM_REQ
//   valid      : at least one requester is pending
module mdio_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [1:0]         last_grant,
  output logic [1:0]         winner,
  output logic               valid
);

  always_comb begin
    winner = 2'd0;
    valid  = 1'b0;
    // off = 1 is the highest priority, off = NUM_REQ is last_grant itself
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!valid && pending[j] && (((int'(last_grant) + off) % NUM_REQ) == j)) begin
          winner = 2'(j);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mdio_arb.sv
// mdio_arb: shares one MDIO driver between NUM_REQ requesters.
//   req_*      : per-requester request pulses, direction, address, write data
//   req_done   : per-requester completion pulse, with shared req_rd_data and
//                req_rd_ack valid alongside it
//   op_*       : command to / completion from the MDIO driver
//   busy       : FSM not idle
//   grant_id   : requester currently or last granted
//   req_overflow, timeout_err : one-cycle error pulses
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | no operation in flight, picking next pending slot
// ST_ISSUE | op_exec high for one cycle towards the driver
// ST_WAIT  | waiting for op_done, timeout timer running
// ST_DONE  | req_done pulse to the winner, slot released
module mdio_arb
  import mdio_pkg::*;
#(
  parameter int          NUM_REQ     = 2,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_exec,
  input  logic [NUM_REQ-1:0]         req_rh_wl,
  input  logic [ADDR_W*NUM_REQ-1:0]  req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]  req_wr_data,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [DATA_W-1:0]          req_rd_data,
  output logic                       req_rd_ack,
  output logic                       op_exec,
  output logic                       op_rh_wl,
  output logic [ADDR_W-1:0]          op_addr,
  output logic [DATA_W-1:0]          op_wr_data,
  input  logic                       op_done,
  input  logic [DATA_W-1:0]          op_rd_data,
  input  logic                       op_rd_ack,
  output logic                       busy,
  output logic [1:0]                 grant_id,
  output logic [NUM_REQ-1:0]         req_overflow,
  output logic                       timeout_err
);

  state_t               state;
  logic [1:0]           last_grant;
  logic [15:0]          tmr;

  logic [NUM_REQ-1:0]   pending;
  logic [NUM_REQ-1:0]   slot_clr;
  logic [NUM_REQ-1:0]   slot_set;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic                 slot_rh_wl   [NUM_REQ];
  logic [ADDR_W-1:0]    slot_addr    [NUM_REQ];
  logic [DATA_W-1:0]    slot_wr_data [NUM_REQ];

  logic [1:0]           pick_winner;
  logic                 pick_valid;
  logic                 sel_rh_wl;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wr_data;

  mdio_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  always_comb begin
    sel_rh_wl    = 1'b0;
    sel_addr     = '0;
    sel_wr_data  = '0;
    slot_clr     = '0;
    grant_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick_winner == 2'(j)) begin
        sel_rh_wl   = slot_rh_wl[j];
        sel_addr    = slot_addr[j];
        sel_wr_data = slot_wr_data[j];
      end
      if (grant_id == 2'(j)) begin
        grant_onehot[j] = 1'b1;
      end
    end
    if (state == ST_DONE) begin
      slot_clr = grant_onehot;
    end
  end

  // A pulse landing on the slot being released in DONE is accepted.
  assign slot_set = req_exec & (~pending | slot_clr);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      req_overflow <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_rh_wl[i]   <= 1'b0;
        slot_addr[i]    <= '0;
        slot_wr_data[i] <= '0;
      end
    end else begin
      req_overflow <= req_exec & pending & ~slot_clr;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (slot_set[i]) begin
          pending[i]      <= 1'b1;
          slot_rh_wl[i]   <= req_rh_wl[i];
          slot_addr[i]    <= req_addr[ADDR_W*i +: ADDR_W];
          slot_wr_data[i] <= req_wr_data[DATA_W*i +: DATA_W];
        end else if (slot_clr[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= 2'(NUM_REQ - 1);
      grant_id    <= 2'd0;
      tmr         <= 16'd0;
      op_exec     <= 1'b0;
      op_rh_wl    <= 1'b0;
      op_addr     <= '0;
      op_wr_data  <= '0;
      req_done    <= '0;
      req_rd_data <= '0;
      req_rd_ack  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id   <= pick_winner;
            op_rh_wl   <= sel_rh_wl;
            op_addr    <= sel_addr;
            op_wr_data <= sel_wr_data;
            op_exec    <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          op_exec <= 1'b0;
          tmr     <= TIMEOUT_CYC;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (op_done) begin
            req_rd_data <= op_rd_data;
            req_rd_ack  <= op_rd_ack;
            req_done    <= grant_onehot;
            state       <= ST_DONE;
          end else if (tmr <= 16'd1) begin
            // timer was loaded with TIMEOUT_CYC, so this is the last WAIT cycle
            req_rd_data <= TIMEOUT_RD_DATA;
            req_rd_ack  <= 1'b1;
            timeout_err <= 1'b1;
            req_done    <= grant_onehot;
            state       <= ST_DONE;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        ST_DONE: begin
          req_done    <= '0;
          timeout_err <= 1'b0;
          last_grant  <= grant_id;
          tmr         <= 16'd0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_arb.sv
module tb_mdio_arb;

  localparam int NUM_REQ = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_exec;
  logic [NUM_REQ-1:0]   req_rh_wl;
  logic [5*NUM_REQ-1:0] req_addr;
  logic [16*NUM_REQ-1:0] req_wr_data;
  logic [NUM_REQ-1:0]   req_done;
  logic [15:0]          req_rd_data;
  logic                 req_rd_ack;
  logic                 op_exec;
  logic                 op_rh_wl;
  logic [4:0]           op_addr;
  logic [15:0]          op_wr_data;
  logic                 op_done;
  logic [15:0]          op_rd_data;
  logic                 op_rd_ack;
  logic                 busy;
  logic [1:0]           grant_id;
  logic [NUM_REQ-1:0]   req_overflow;
  logic                 timeout_err;

  typedef struct {
    logic [1:0]  id;
    logic        rh;
    logic [4:0]  addr;
    logic [15:0] wd;
  } op_t;

  typedef struct {
    logic [NUM_REQ-1:0] done;
    logic [15:0]        rd;
    logic               ack;
    logic               terr;
  } rsp_t;

  op_t  exp_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mdio_arb #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(16'd1000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_exec     (req_exec),
    .req_rh_wl    (req_rh_wl),
    .req_addr     (req_addr),
    .req_wr_data  (req_wr_data),
    .req_done     (req_done),
    .req_rd_data  (req_rd_data),
    .req_rd_ack   (req_rd_ack),
    .op_exec      (op_exec),
    .op_rh_wl     (op_rh_wl),
    .op_addr      (op_addr),
    .op_wr_data   (op_wr_data),
    .op_done      (op_done),
    .op_rd_data   (op_rd_data),
    .op_rd_ack    (op_rd_ack),
    .busy         (busy),
    .grant_id     (grant_id),
    .req_overflow (req_overflow),
    .timeout_err  (timeout_err)
  );

  // Loads one requester's fields and records the operation it should produce.
  task automatic set_slot(input int id, input logic rh, input logic [4:0] a, input logic [15:0] d);
    op_t e;
    req_rh_wl[id]          = rh;
    req_addr[5*id +: 5]    = a;
    req_wr_data[16*id +: 16] = d;
    e.id = 2'(id); e.rh = rh; e.addr = a; e.wd = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_exec(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (op_exec === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns op_done for one cycle; ends at the negedge of the DONE cycle.
  task automatic complete_op(input int id, input logic [15:0] d, input logic ack);
    rsp_t r;
    @(posedge clk); #1;
    op_done = 1'b1; op_rd_data = d; op_rd_ack = ack;
    r.done = '0; r.done[id] = 1'b1; r.rd = d; r.ack = ack; r.terr = 1'b0;
    rsp_q.push_back(r);
    @(posedge clk); #1;
    op_done = 1'b0; op_rd_data = 16'h0000; op_rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || op_exec !== 1'b0) begin
      bad++; $display("FAIL reset_busy_exec: got busy=%b op_exec=%b want 0 0", busy, op_exec);
    end
    total++;
    if ({req_done, req_overflow, timeout_err, req_rd_ack} !== '0) begin
      bad++; $display("FAIL reset_pulses: got done=%b ovf=%b terr=%b ack=%b want 0", req_done, req_overflow, timeout_err, req_rd_ack);
    end
    total++;
    if (req_rd_data !== 16'h0000 || grant_id !== 2'd0 || op_addr !== 5'd0 || op_wr_data !== 16'd0 || op_rh_wl !== 1'b0) begin
      bad++; $display("FAIL reset_data: got rd=%h gid=%0d addr=%h wd=%h rh=%b want all 0", req_rd_data, grant_id, op_addr, op_wr_data, op_rh_wl);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write;
    op_t e; rsp_t r;
    @(posedge clk); #1;
    set_slot(0, 1'b0, 5'h00, 16'h8000);
    req_exec = 2'b01;
    @(posedge clk); #1;
    req_exec = 2'b00;
    @(negedge clk);
    total++;
    if (op_exec !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL wr_latency_t1: got op_exec=%b busy=%b want 0 0", op_exec, busy);
    end
    @(negedge clk);
    total++;
    if (op_exec !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL wr_latency_t2: got op_exec=%b busy=%b want 1 1", op_exec, busy);
    end
    e = exp_q.pop_front();
    total++;
    if ({op_rh_wl, op_addr, op_wr_data, grant_id} !== {e.rh, e.addr, e.wd, e.id}) begin
      bad++; $display("FAIL wr_fields: got rh=%b addr=%h wd=%h gid=%0d want %b %h %h %0d", op_rh_wl, op_addr, op_wr_data, grant_id, e.rh, e.addr, e.wd, e.id);
    end
    @(negedge clk);
    total++;
    if (op_exec !== 1'b0) begin
      bad++; $display("FAIL wr_exec_one_cycle: got op_exec=%b want 0", op_exec);
    end
    complete_op(0, 16'h1234, 1'b0);
    r = rsp_q.pop_front();
    total++;
    if (req_done !== r.done || timeout_err !== r.terr || op_addr !== e.addr || op_wr_data !== e.wd) begin
      bad++; $display("FAIL wr_done: got done=%b terr=%b addr=%h wd=%h want %b %b %h %h", req_done, timeout_err, op_addr, op_wr_data, r.done, r.terr, e.addr, e.wd);
    end
    @(negedge clk);
    total++;
    if (req_done !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL wr_back_idle: got done=%b busy=%b want 00 0", req_done, busy);
    end
  endtask

  task automatic test_read;
    op_t e; rsp_t r; bit ok;
    @(posedge clk); #1;
    set_slot(1, 1'b1, 5'h02, 16'h0000);
    req_exec = 2'b10;
    @(posedge clk); #1;
    req_exec = 2'b00;
    wait_exec(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rd_exec_timeout: got no op_exec want op_exec within 50 cycles");
    end
    e = exp_q.pop_front();
    total++;
    if ({op_rh_wl, op_addr, grant_id} !== {e.rh, e.addr, e.id}) begin
      bad++; $display("FAIL rd_fields: got rh=%b addr=%h gid=%0d want %b %h %0d", op_rh_wl, op_addr, grant_id, e.rh, e.addr, e.id);
    end
    complete_op(1, 16'h0141, 1'b0);
    r = rsp_q.pop_front();
    total++;
    if (req_done !== r.done || req_rd_data !== r.rd || req_rd_ack !== r.ack) begin
      bad++; $display("FAIL rd_result: got done=%b rd=%h ack=%b want %b %h %b", req_done, req_rd_data, req_rd_ack, r.done, r.rd, r.ack);
    end
  endtask

  task automatic test_contention;
    op_t e; rsp_t r; bit ok; int gap;
    @(posedge clk); #1;
    set_slot(0, 1'b0, 5'h04, 16'hA5A5);
    set_slot(1, 1'b1, 5'h11, 16'h0000);
    req_exec = 2'b11;
    @(posedge clk); #1;
    req_exec = 2'b00;
    wait_exec(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL cont_exec_timeout: got no op_exec want op_exec within 50 cycles");
    end
    e = exp_q.pop_front();
    total++;
    if ({op_rh_wl, op_addr, op_wr_data, grant_id} !== {e.rh, e.addr, e.wd, e.id}) begin
      bad++; $display("FAIL cont_first: got rh=%b addr=%h wd=%h gid=%0d want %b %h %h %0d", op_rh_wl, op_addr, op_wr_data, grant_id, e.rh, e.addr, e.wd, e.id);
    end
    complete_op(0, 16'h0000, 1'b0);
    r = rsp_q.pop_front();
    total++;
    if (req_done !== r.done) begin
      bad++; $display("FAIL cont_done0: got done=%b want %b", req_done, r.done);
    end
    gap = 99;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (op_exec === 1'b1) begin
        gap = k + 1;
        break;
      end
    end
    total++;
    if (gap != 2) begin
      bad++; $display("FAIL cont_gap: got %0d cycles DONE->op_exec want 2", gap);
    end
    e = exp_q.pop_front();
    total++;
    if ({op_rh_wl, op_addr, grant_id} !== {e.rh, e.addr, e.id}) begin
      bad++; $display("FAIL cont_second: got rh=%b addr=%h gid=%0d want %b %h %0d", op_rh_wl, op_addr, grant_id, e.rh, e.addr, e.id);
    end
    complete_op(1, 16'hBEEF, 1'b1);
    r = rsp_q.pop_front();
    total++;
    if (req_done !== r.done || req_rd_data !== r.rd || req_rd_ack !== r.ack) begin
      bad++; $display("FAIL cont_done1: got done=%b rd=%h ack=%b want %b %h %b", req_done, req_rd_data, req_rd_ack, r.done, r.rd, r.ack);
    end
  endtask

  task automatic test_overflow;
    op_t e; rsp_t r; bit ok; int extra_ops; int extra_ovf;
    @(posedge clk); #1;
    set_slot(0, 1'b0, 5'h05, 16'hAAAA);
    req_exec = 2'b01;
    @(posedge clk); #1;
    req_exec = 2'b00;
    wait_exec(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL ovf_exec_timeout: got no op_exec want op_exec within 50 cycles");
    end
    e = exp_q.pop_front();
    // second pulse while the slot is still pending (operation in flight)
    @(posedge clk); #1;
    req_addr[4:0] = 5'h06; req_wr_data[15:0] = 16'h5555;
    req_exec = 2'b01;
    @(posedge clk); #1;
    req_exec = 2'b00;
    @(negedge clk);
    total++;
    if (req_overflow !== 2'b01) begin
      bad++; $display("FAIL ovf_pulse: got req_overflow=%b want 01", req_overflow);
    end
    @(negedge clk);
    total++;
    if (req_overflow !== 2'b00) begin
      bad++; $display("FAIL ovf_one_cycle: got req_overflow=%b want 00", req_overflow);
    end
    complete_op(0, 16'h0000, 1'b0);
    r = rsp_q.pop_front();
    total++;
    if (req_done !== r.done || op_addr !== e.addr || op_wr_data !== e.wd) begin
      bad++; $display("FAIL ovf_done: got done=%b addr=%h wd=%h want %b %h %h", req_done, op_addr, op_wr_data, r.done, e.addr, e.wd);
    end
    extra_ops = 0; extra_ovf = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (op_exec === 1'b1) extra_ops++;
      if (req_overflow !== 2'b00) extra_ovf++;
    end
    total++;
    if (extra_ops != 0 || extra_ovf != 0) begin
      bad++; $display("FAIL ovf_single_op: got extra ops=%0d ovf=%0d want 0 0", extra_ops, extra_ovf);
    end
  endtask

  task automatic test_timeout;
    op_t e; rsp_t r; bit ok; int n; int stray;
    @(posedge clk); #1;
    set_slot(1, 1'b1, 5'h03, 16'h0000);
    req_exec = 2'b10;
    @(posedge clk); #1;
    req_exec = 2'b00;
    wait_exec(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL to_exec_timeout: got no op_exec want op_exec within 50 cycles");
    end
    e = exp_q.pop_front();
    r.done = 2'b10; r.rd = 16'hFFFF; r.ack = 1'b1; r.terr = 1'b1;
    rsp_q.push_back(r);
    n = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      n++;
      if (timeout_err === 1'b1) break;
    end
    total++;
    if (n != 1001) begin
      bad++; $display("FAIL to_cycles: got timeout_err after %0d cycles from op_exec want 1001", n);
    end
    r = rsp_q.pop_front();
    total++;
    if (timeout_err !== r.terr || req_done !== r.done || req_rd_data !== r.rd || req_rd_ack !== r.ack) begin
      bad++; $display("FAIL to_result: got terr=%b done=%b rd=%h ack=%b want %b %b %h %b", timeout_err, req_done, req_rd_data, req_rd_ack, r.terr, r.done, r.rd, r.ack);
    end
    @(negedge clk);
    total++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL to_pulse_end: got terr=%b busy=%b want 0 0", timeout_err, busy);
    end
    // stray op_done while idle
    @(posedge clk); #1;
    op_done = 1'b1; op_rd_data = 16'h5555;
    @(posedge clk); #1;
    op_done = 1'b0; op_rd_data = 16'h0000;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || req_done !== 2'b00 || op_exec !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL stray_op_done: got %0d reacting cycles want 0", stray);
    end
    @(posedge clk); #1;
    set_slot(0, 1'b1, 5'h07, 16'h0000);
    req_exec = 2'b01;
    @(posedge clk); #1;
    req_exec = 2'b00;
    wait_exec(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {op_rh_wl, op_addr, grant_id} !== {e.rh, e.addr, e.id}) begin
      bad++; $display("FAIL to_next_issue: got ok=%b rh=%b addr=%h gid=%0d want 1 %b %h %0d", ok, op_rh_wl, op_addr, grant_id, e.rh, e.addr, e.id);
    end
    complete_op(0, 16'h0BEE, 1'b0);
    r = rsp_q.pop_front();
    total++;
    if (req_done !== r.done || req_rd_data !== r.rd || req_rd_ack !== r.ack || timeout_err !== 1'b0) begin
      bad++; $display("FAIL to_next_done: got done=%b rd=%h ack=%b terr=%b want %b %h %b 0", req_done, req_rd_data, req_rd_ack, timeout_err, r.done, r.rd, r.ack);
    end
  endtask

  task automatic test_reset_mid_wait;
    bit ok; int during; int after;
    @(posedge clk); #1;
    set_slot(0, 1'b0, 5'h09, 16'h1111);
    req_exec = 2'b01;
    @(posedge clk); #1;
    req_exec = 2'b00;
    wait_exec(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rst_exec_timeout: got no op_exec want op_exec within 50 cycles");
    end
    @(posedge clk); #1;
    set_slot(1, 1'b1, 5'h0A, 16'h0000);
    req_exec = 2'b10;
    @(posedge clk); #1;
    req_exec = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    during = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || req_done !== 2'b00 || op_exec !== 1'b0) during++;
    end
    total++;
    if (during != 0) begin
      bad++; $display("FAIL rst_during: got %0d active cycles in reset want 0", during);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    after = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || req_done !== 2'b00 || op_exec !== 1'b0) after++;
    end
    total++;
    if (after != 0) begin
      bad++; $display("FAIL rst_slots_empty: got %0d active cycles after reset want 0", after);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_exec    = '0;
    req_rh_wl   = '0;
    req_addr    = '0;
    req_wr_data = '0;
    op_done     = 1'b0;
    op_rd_data  = 16'h0000;
    op_rd_ack   = 1'b0;
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_overflow();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_arb.md
MDIO_ARB -- requirements
Module: mdio_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one MDIO driver; the legal range is 2..4.
REQ-002 Parameter TIMEOUT_CYC, default 16'd1000, is the maximum number of clk cycles spent waiting for op_done before the operation is aborted.
REQ-003 clk  in  1  is the MDIO driver operation clock (dri_clk); all logic is synchronous to its rising edge.
REQ-004 rst_n  in  1  is the reset: asynchronous assert, active-low.
REQ-005 req_exec  in  NUM_REQ  carries one-cycle operation request pulses, one bit per requester.
REQ-006 req_rh_wl  in  NUM_REQ  selects the direction per requester: 1 = read, 0 = write.
REQ-007 req_addr  in  5*NUM_REQ  holds the PHY register address per requester; requester i uses bits [5i+4:5i].
REQ-008 req_wr_data  in  16*NUM_REQ  holds the write data per requester; requester i uses bits [16i+15:16i].
REQ-009 req_done  out  NUM_REQ  carries the one-cycle completion pulse per requester.
REQ-010 req_rd_data  out  16  is the shared read result, valid only while some req_done bit is high.
REQ-011 req_rd_ack  out  1  is the shared PHY acknowledge status (0 = PHY acknowledged), valid with req_done.
REQ-012 op_exec, op_rh_wl, op_addr[4:0], op_wr_data[15:0]  out  carry the command to the MDIO driver.
REQ-013 op_done, op_rd_data[15:0], op_rd_ack  in  carry the completion from the MDIO driver.
REQ-014 busy  out  1  is high whenever the FSM is not IDLE.
REQ-015 grant_id  out  2  is the index of the requester currently or last granted.
REQ-016 req_overflow  out  NUM_REQ  pulses for one cycle when a request is dropped.
REQ-017 timeout_err  out  1  pulses for one cycle when an operation times out.

Function
REQ-018 Each requester shall own one pending slot; a req_exec pulse shall capture rh_wl/addr/wr_data into the slot and set pending at the next edge.
REQ-019 A req_exec pulse on a requester whose slot is already pending (and not being cleared that cycle) shall be ignored and shall pulse that requester's req_overflow bit.
REQ-020 A new pulse in the same cycle its slot is cleared shall be captured; set shall win over clear.
REQ-021 FSM states shall be IDLE, ISSUE, WAIT and DONE.
REQ-022 IDLE -> ISSUE occurs when any slot is pending; the winner is chosen round-robin, searching upward from last_grant+1 modulo NUM_REQ.
REQ-023 In ISSUE, op_exec shall be high for exactly one cycle, followed by an unconditional move to WAIT.
REQ-024 op_rh_wl, op_addr and op_wr_data shall be loaded from the winner's slot on entering ISSUE and held stable until IDLE is re-entered.
REQ-025 Latency: req_exec at cycle T gives pending at T+1 and op_exec=1 at T+2 when the FSM is idle.
REQ-026 WAIT -> DONE occurs on op_done=1; op_rd_data and op_rd_ack shall be registered into req_rd_data and req_rd_ack.
REQ-027 In WAIT, a cycle counter shall reach TIMEOUT_CYC without op_done -> DONE with req_rd_data=16'hFFFF, req_rd_ack=1, and timeout_err pulsed.
REQ-028 In DONE (one cycle), the winner's req_done bit shall be high, its slot cleared, last_grant updated, and the FSM shall return to IDLE.
REQ-029 Back-to-back operations shall reach op_exec at the earliest 2 cycles after DONE.
REQ-030 An op_done arriving outside WAIT shall be ignored.
REQ-031 No requester shall wait more than NUM_REQ-1 operations while its slot is pending.

Reset
REQ-032 While rst_n=0: all slots cleared, FSM=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), timeout counter=0, and all outputs 0 except req_rd_data=0.
REQ-033 Reset asserted mid-operation shall abort without issuing req_done; requesters shall re-request after reset.

Structure
REQ-034 Package mdio_pkg shall hold the address width (5), data width (16), FSM state encoding, and the TIMEOUT read value 16'hFFFF.
REQ-035 The round-robin selection shall be a sub-module mdio_rr_pick (pending vector + last_grant -> winner index + valid); it shall be purely combinational.

Verification
REQ-036 Single write: requester 0 pulses write, addr 5'h00, data 16'h8000 -> op_exec at T+2 with matching op fields; op_done returned -> req_done[0] next cycle, req_done[1]=0.
REQ-037 Read: requester 1 reads addr 5'h02; driver returns 16'h0141 with ack 0 -> req_rd_data=16'h0141, req_rd_ack=0 with req_done[1].
REQ-038 Contention: both requesters pulse in the same cycle after reset -> requester 0 served first, requester 1 second, with no idle gaps beyond 2 cycles.
REQ-039 Overflow: requester 0 pulses twice while pending -> one req_overflow[0] pulse and exactly one operation issued.
REQ-040 Timeout: driver never asserts op_done -> after 1000 WAIT cycles, timeout_err=1 and req_done with 16'hFFFF / ack 1; the next request proceeds normally.
REQ-041 Reset mid-WAIT: rst_n low for 3 cycles -> busy=0, no req_done, and all slots empty.
